// File: rtl/branch_pkg.sv
// Shared types and constants for the branch resolve unit.
package branch_pkg;

  // Compare-mode encoding; 3'b010 and 3'b011 are reserved and flagged illegal.
  typedef enum logic [2:0] {
    BrEq  = 3'b000,
    BrNe  = 3'b001,
    BrLt  = 3'b100,
    BrGe  = 3'b101,
    BrLtu = 3'b110,
    BrGeu = 3'b111
  } br_ctrl_e;

  // Byte distance from a branch to the next sequential instruction.
  localparam int unsigned FallThroughInc = 4;

  // Per-stage result flags; the XLEN-wide redirect PC travels alongside.
  typedef struct packed {
    logic taken;
    logic mispredict;
    logic illegal;
  } br_payload_t;

endpackage

// File: rtl/branch_cmp.sv
// Combinational branch condition evaluation for all compare modes.
module branch_cmp
  import branch_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      ctrl,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            taken,
  output logic            illegal
);

  // Decode the compare mode; reserved encodings resolve not-taken.
  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (ctrl)
      BrEq:    taken = (src_a == src_b);
      BrNe:    taken = (src_a != src_b);
      BrLt:    taken = ($signed(src_a) < $signed(src_b));
      BrGe:    taken = ($signed(src_a) >= $signed(src_b));
      BrLtu:   taken = (src_a < src_b);
      BrGeu:   taken = (src_a >= src_b);
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolution pipeline: compare, misprediction check, redirect PC and
// statistics, behind a valid/ready handshake with 1 or 2 register stages.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned STAGES = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [2:0]       Br_Ctrl,
  input  logic [XLEN-1:0]  SrcA,
  input  logic [XLEN-1:0]  SrcB,
  input  logic [XLEN-1:0]  PC,
  input  logic [XLEN-1:0]  Imm,
  input  logic             Pred_Taken,
  input  logic [XLEN-1:0]  Pred_Target,
  input  logic             Flush,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic             BrOut,
  output logic             Mispredict,
  output logic [XLEN-1:0]  Redirect_PC,
  output logic             Illegal,
  output logic [CNT_W-1:0] Br_Cnt,
  output logic [CNT_W-1:0] Mis_Cnt
);

  logic            cmp_taken, cmp_illegal;
  logic            br_taken;
  logic [XLEN-1:0] target, fall_through;
  br_payload_t     new_pl;
  logic [XLEN-1:0] new_redirect;

  logic            accept, out_xfer, s1_drain;
  logic            s1_valid_q;
  br_payload_t     s1_pl_q;
  logic [XLEN-1:0] s1_pc_q;
  logic            last_valid;
  br_payload_t     last_pl;
  logic [XLEN-1:0] last_pc;

  logic [CNT_W-1:0] br_cnt_q, mis_cnt_q;

  branch_cmp #(
    .XLEN (XLEN)
  ) u_cmp (
    .ctrl    (Br_Ctrl),
    .src_a   (SrcA),
    .src_b   (SrcB),
    .taken   (cmp_taken),
    .illegal (cmp_illegal)
  );

  // Resolve the incoming request: targets wrap silently at XLEN.
  always_comb begin
    target            = PC + Imm;
    fall_through      = PC + XLEN'(FallThroughInc);
    br_taken          = cmp_taken & ~cmp_illegal;
    new_pl.taken      = br_taken;
    new_pl.illegal    = cmp_illegal;
    new_pl.mispredict = (br_taken != Pred_Taken) |
                        (br_taken & Pred_Taken & (Pred_Target != target));
    new_redirect      = br_taken ? target : fall_through;
  end

  // Flush and reset both block acceptance for the cycle they are asserted.
  assign In_Ready  = ~rst & ~Flush & (~s1_valid_q | s1_drain);
  assign accept    = In_Valid & In_Ready;
  assign Out_Valid = last_valid & ~Flush;
  assign out_xfer  = Out_Valid & Out_Ready;

  // First stage: load on accept, hold payload otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_pl_q    <= '0;
      s1_pc_q    <= '0;
    end else begin
      if (Flush) begin
        s1_valid_q <= 1'b0;
      end else if (~s1_valid_q | s1_drain) begin
        s1_valid_q <= accept;
      end
      if (accept) begin
        s1_pl_q <= new_pl;
        s1_pc_q <= new_redirect;
      end
    end
  end

  if (STAGES == 2) begin : g_two_stage
    logic            s2_valid_q;
    br_payload_t     s2_pl_q;
    logic [XLEN-1:0] s2_pc_q;

    assign s1_drain   = ~s2_valid_q | Out_Ready;
    assign last_valid = s2_valid_q;
    assign last_pl    = s2_pl_q;
    assign last_pc    = s2_pc_q;

    // Second stage: advance from stage 1 whenever the output slot frees up.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s2_valid_q <= 1'b0;
        s2_pl_q    <= '0;
        s2_pc_q    <= '0;
      end else begin
        if (Flush) begin
          s2_valid_q <= 1'b0;
        end else if (s1_drain) begin
          s2_valid_q <= s1_valid_q;
        end
        if (s1_valid_q & s1_drain & ~Flush) begin
          s2_pl_q <= s1_pl_q;
          s2_pc_q <= s1_pc_q;
        end
      end
    end
  end else begin : g_one_stage
    assign s1_drain   = Out_Ready;
    assign last_valid = s1_valid_q;
    assign last_pl    = s1_pl_q;
    assign last_pc    = s1_pc_q;
  end

  assign BrOut       = last_pl.taken;
  assign Mispredict  = last_pl.mispredict;
  assign Illegal     = last_pl.illegal;
  assign Redirect_PC = last_pc;

  // Saturating statistics, bumped only on a real output transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else if (out_xfer) begin
      if (~last_pl.illegal && (br_cnt_q != '1)) begin
        br_cnt_q <= br_cnt_q + 1'b1;
      end
      if (last_pl.mispredict && (mis_cnt_q != '1)) begin
        mis_cnt_q <= mis_cnt_q + 1'b1;
      end
    end
  end

  assign Br_Cnt  = br_cnt_q;
  assign Mis_Cnt = mis_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench: one single-stage DUT and one two-stage, small-counter DUT
// share stimulus; each keeps its own queue of expected results.
module tb_branch_resolve_unit;

  typedef struct packed {
    logic        br;
    logic        mis;
    logic        ill;
    logic [31:0] rpc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, In_Valid, Flush, Out_Ready, Pred_Taken;
  logic [2:0]  Br_Ctrl;
  logic [31:0] SrcA, SrcB, PC, Imm, Pred_Target;

  logic        rdy1, ov1, br1, mis1, ill1;
  logic [31:0] rpc1;
  logic [15:0] bc1, mc1;
  logic        rdy2, ov2, br2, mis2, ill2;
  logic [31:0] rpc2;
  logic [3:0]  bc2, mc2;

  exp_t q1[$];
  exp_t q2[$];
  exp_t cur_exp;
  int   n_tests = 0;
  int   n_fail = 0;
  int   eb1 = 0, em1 = 0, eb2 = 0, em2 = 0;
  int   xfer2 = 0;
  int   ncyc = 0;
  logic rand_ready = 1'b0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.XLEN(32), .STAGES(1), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst(rst), .In_Valid(In_Valid), .In_Ready(rdy1), .Br_Ctrl(Br_Ctrl),
    .SrcA(SrcA), .SrcB(SrcB), .PC(PC), .Imm(Imm), .Pred_Taken(Pred_Taken),
    .Pred_Target(Pred_Target), .Flush(Flush), .Out_Valid(ov1), .Out_Ready(Out_Ready),
    .BrOut(br1), .Mispredict(mis1), .Redirect_PC(rpc1), .Illegal(ill1),
    .Br_Cnt(bc1), .Mis_Cnt(mc1)
  );

  branch_resolve_unit #(.XLEN(32), .STAGES(2), .CNT_W(4)) u_dut2 (
    .clk(clk), .rst(rst), .In_Valid(In_Valid), .In_Ready(rdy2), .Br_Ctrl(Br_Ctrl),
    .SrcA(SrcA), .SrcB(SrcB), .PC(PC), .Imm(Imm), .Pred_Taken(Pred_Taken),
    .Pred_Target(Pred_Target), .Flush(Flush), .Out_Valid(ov2), .Out_Ready(Out_Ready),
    .BrOut(br2), .Mispredict(mis2), .Redirect_PC(rpc2), .Illegal(ill2),
    .Br_Cnt(bc2), .Mis_Cnt(mc2)
  );

  function automatic exp_t mk_exp(input logic br, input logic mis, input logic ill,
                                  input logic [31:0] rpc);
    exp_t e;
    e.br = br; e.mis = mis; e.ill = ill; e.rpc = rpc;
    return e;
  endfunction

  // Reference behaviour derived from the compare table and redirect rules.
  function automatic exp_t model(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] pc, input logic [31:0] imm,
                                 input logic pt, input logic [31:0] ptgt);
    exp_t        e;
    logic        t;
    logic [31:0] tgt;
    e.ill = 1'b0;
    t     = 1'b0;
    case (c)
      3'b000:  t = (a == b);
      3'b001:  t = (a != b);
      3'b100:  t = ($signed(a) < $signed(b));
      3'b101:  t = ($signed(a) >= $signed(b));
      3'b110:  t = (a < b);
      3'b111:  t = (a >= b);
      default: e.ill = 1'b1;
    endcase
    tgt   = pc + imm;
    e.br  = t;
    e.rpc = t ? tgt : pc + 32'd4;
    e.mis = (t != pt) || (t && pt && (ptgt != tgt));
    return e;
  endfunction

  // One clock: sample just before the rising edge, check outputs, record
  // accepts, then return at the following falling edge.
  task automatic cycle(output logic acc2, output logic r1, output logic r2);
    exp_t e;
    #4;
    r1   = rdy1;
    r2   = rdy2;
    acc2 = In_Valid & rdy2;
    if (ov1) begin
      n_tests++;
      if (q1.size() == 0) begin
        n_fail++;
        $display("FAIL dut1_unexpected_out: Out_Valid=1 rpc=%h, required no output", rpc1);
      end else begin
        e = q1[0];
        if ({br1, mis1, ill1, rpc1} !== {e.br, e.mis, e.ill, e.rpc}) begin
          n_fail++;
          $display("FAIL dut1_result: got br=%0b mis=%0b ill=%0b rpc=%h, want br=%0b mis=%0b ill=%0b rpc=%h",
                   br1, mis1, ill1, rpc1, e.br, e.mis, e.ill, e.rpc);
        end
        if (Out_Ready) begin
          void'(q1.pop_front());
          if (!e.ill && eb1 < 65535) eb1++;
          if (e.mis && em1 < 65535) em1++;
        end
      end
    end
    if (ov2) begin
      n_tests++;
      if (q2.size() == 0) begin
        n_fail++;
        $display("FAIL dut2_unexpected_out: Out_Valid=1 rpc=%h, required no output", rpc2);
      end else begin
        e = q2[0];
        if ({br2, mis2, ill2, rpc2} !== {e.br, e.mis, e.ill, e.rpc}) begin
          n_fail++;
          $display("FAIL dut2_result: got br=%0b mis=%0b ill=%0b rpc=%h, want br=%0b mis=%0b ill=%0b rpc=%h",
                   br2, mis2, ill2, rpc2, e.br, e.mis, e.ill, e.rpc);
        end
        if (Out_Ready) begin
          void'(q2.pop_front());
          xfer2++;
          if (!e.ill && eb2 < 15) eb2++;
          if (e.mis && em2 < 15) em2++;
        end
      end
    end
    if (In_Valid && rdy1) q1.push_back(cur_exp);
    if (In_Valid && rdy2) q2.push_back(cur_exp);
    if (Flush || rst) begin
      q1.delete();
      q2.delete();
    end
    if (rst) begin
      eb1 = 0; em1 = 0; eb2 = 0; em2 = 0;
    end
    ncyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Hold a request until the two-stage DUT takes it.
  task automatic offer(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic [31:0] imm, input logic pt,
                       input logic [31:0] ptgt, input exp_t e);
    logic acc, r1, r2;
    Br_Ctrl = c; SrcA = a; SrcB = b; PC = pc; Imm = imm;
    Pred_Taken = pt; Pred_Target = ptgt; cur_exp = e;
    In_Valid = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < 50 && !acc; k++) begin
      if (rand_ready) Out_Ready = 1'($urandom_range(0, 1));
      cycle(acc, r1, r2);
    end
    In_Valid = 1'b0;
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL offer_timeout: accepted=0, required 1");
    end
  endtask

  task automatic drain();
    logic a, r1, r2;
    In_Valid = 1'b0;
    Out_Ready = 1'b1;
    rand_ready = 1'b0;
    for (int k = 0; k < 20 && (q1.size() != 0 || q2.size() != 0); k++) cycle(a, r1, r2);
    n_tests++;
    if (q1.size() != 0 || q2.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: pending %0d/%0d, required 0/0", q1.size(), q2.size());
    end
  endtask

  task automatic do_reset();
    logic a, r1, r2;
    rst = 1'b1; In_Valid = 1'b0; Flush = 1'b0;
    cycle(a, r1, r2);
    rst = 1'b0;
  endtask

  task automatic check_counts(input string tag, input int b1, input int m1, input int b2,
                              input int m2);
    n_tests++;
    if ({bc1, mc1, bc2, mc2} !== {16'(b1), 16'(m1), 4'(b2), 4'(m2)}) begin
      n_fail++;
      $display("FAIL %s_counts: got %0d/%0d %0d/%0d, want %0d/%0d %0d/%0d",
               tag, bc1, mc1, bc2, mc2, b1, m1, b2, m2);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_tests++;
    if ({ov1, rdy1, br1, mis1, ill1, rpc1, bc1, mc1} !== '0) begin
      n_fail++;
      $display("FAIL reset_dut1: got ov=%0b rdy=%0b br=%0b mis=%0b ill=%0b rpc=%h, want all 0",
               ov1, rdy1, br1, mis1, ill1, rpc1);
    end
    n_tests++;
    if ({ov2, rdy2, br2, mis2, ill2, rpc2, bc2, mc2} !== '0) begin
      n_fail++;
      $display("FAIL reset_dut2: got ov=%0b rdy=%0b br=%0b mis=%0b ill=%0b rpc=%h, want all 0",
               ov2, rdy2, br2, mis2, ill2, rpc2);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if ({rdy1, rdy2} !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b, want 11", {rdy1, rdy2});
    end
    @(negedge clk);
  endtask

  task automatic test_latency();
    logic a, r1, r2;
    do_reset();
    Out_Ready = 1'b0;
    offer(3'b000, 32'd1, 32'd1, 32'h40, 32'h8, 1'b1, 32'h48, mk_exp(1'b1, 1'b0, 1'b0, 32'h48));
    n_tests++;
    if ({ov1, ov2} !== 2'b10) begin
      n_fail++;
      $display("FAIL latency_first: got ov1,ov2=%b, want 10", {ov1, ov2});
    end
    cycle(a, r1, r2);
    n_tests++;
    if ({ov1, ov2} !== 2'b11) begin
      n_fail++;
      $display("FAIL latency_second: got ov1,ov2=%b, want 11", {ov1, ov2});
    end
    drain();
  endtask

  task automatic test_compare();
    int c0;
    do_reset();
    Out_Ready = 1'b1;
    c0 = ncyc;
    offer(3'b100, 32'hFFFFFFFF, 32'h1, 32'h100, 32'h20, 1'b1, 32'h120,
          mk_exp(1'b1, 1'b0, 1'b0, 32'h120));
    offer(3'b110, 32'hFFFFFFFF, 32'h1, 32'h100, 32'h20, 1'b1, 32'h120,
          mk_exp(1'b0, 1'b1, 1'b0, 32'h104));
    offer(3'b000, 32'h5, 32'h5, 32'h1000, 32'h10, 1'b1, 32'h1020,
          mk_exp(1'b1, 1'b1, 1'b0, 32'h1010));
    offer(3'b001, 32'h7, 32'h7, 32'hFFFFFFFC, 32'h8, 1'b0, 32'h0,
          mk_exp(1'b0, 1'b0, 1'b0, 32'h0));
    offer(3'b101, 32'h80000000, 32'h0, 32'h200, 32'h40, 1'b0, 32'h0,
          mk_exp(1'b0, 1'b0, 1'b0, 32'h204));
    offer(3'b111, 32'h80000000, 32'h0, 32'h200, 32'hFFFFFFF0, 1'b1, 32'h1F0,
          mk_exp(1'b1, 1'b0, 1'b0, 32'h1F0));
    offer(3'b011, 32'h3, 32'h3, 32'h300, 32'h40, 1'b1, 32'h340,
          mk_exp(1'b0, 1'b1, 1'b1, 32'h304));
    offer(3'b010, 32'h3, 32'h4, 32'h400, 32'h40, 1'b0, 32'h0,
          mk_exp(1'b0, 1'b0, 1'b1, 32'h404));
    offer(3'b100, 32'h1, 32'h2, 32'hFFFFFFF0, 32'h20, 1'b1, 32'h10,
          mk_exp(1'b1, 1'b0, 1'b0, 32'h10));
    offer(3'b001, 32'h1, 32'h2, 32'h500, 32'h40, 1'b0, 32'h0,
          mk_exp(1'b1, 1'b1, 1'b0, 32'h540));
    n_tests++;
    if (ncyc - c0 != 10) begin
      n_fail++;
      $display("FAIL compare_throughput: got %0d cycles for 10 requests, want 10", ncyc - c0);
    end
    drain();
    check_counts("compare", 8, 4, 8, 4);
  endtask

  task automatic test_back_to_back();
    logic acc, r1, r2;
    int   idx, x0;
    do_reset();
    idx = 0;
    x0  = xfer2;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (idx >= 4 && q2.size() == 0) break;
      Out_Ready = (cyc >= 3);
      if (idx < 4) begin
        Br_Ctrl = 3'b000; SrcA = 32'(idx); SrcB = 32'(idx);
        PC = 32'h1000 + 32'(16 * idx); Imm = 32'h100;
        Pred_Taken = 1'b1; Pred_Target = PC + 32'h100;
        cur_exp = mk_exp(1'b1, 1'b0, 1'b0, PC + 32'h100);
        In_Valid = 1'b1;
      end else begin
        In_Valid = 1'b0;
      end
      cycle(acc, r1, r2);
      if (cyc == 1) begin
        n_tests++;
        if (r1 !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_stall_ready_dut1: got %b, want 0", r1);
        end
      end
      if (cyc == 2) begin
        n_tests++;
        if (r2 !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_stall_ready_dut2: got %b, want 0", r2);
        end
      end
      if (acc) idx++;
    end
    In_Valid = 1'b0;
    n_tests++;
    if (idx != 4 || q2.size() != 0 || xfer2 - x0 != 4) begin
      n_fail++;
      $display("FAIL b2b_transfers: got accepted=%0d transferred=%0d, want 4/4", idx, xfer2 - x0);
    end
    n_tests++;
    if (bc2 !== 4'd4) begin
      n_fail++;
      $display("FAIL b2b_br_cnt: got %0d, want 4", bc2);
    end
    drain();
  endtask

  task automatic test_random();
    logic [2:0]  c;
    logic [31:0] a, b, pc, imm, ptgt;
    logic        pt;
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      c    = 3'($urandom_range(0, 7));
      a    = $urandom;
      b    = ($urandom_range(0, 2) == 0) ? a : $urandom;
      pc   = $urandom;
      imm  = $urandom;
      pt   = 1'($urandom_range(0, 1));
      ptgt = ($urandom_range(0, 1) == 1) ? pc + imm : $urandom;
      offer(c, a, b, pc, imm, pt, ptgt, model(c, a, b, pc, imm, pt, ptgt));
    end
    drain();
    check_counts("random", eb1, em1, eb2, em2);
  endtask

  task automatic test_flush();
    logic a, r1, r2;
    do_reset();
    Out_Ready = 1'b1;
    offer(3'b000, 32'h9, 32'h9, 32'h600, 32'h20, 1'b0, 32'h0, mk_exp(1'b1, 1'b1, 1'b0, 32'h620));
    drain();
    check_counts("flush_pre", 1, 1, 1, 1);
    Out_Ready = 1'b0;
    offer(3'b000, 32'h1, 32'h1, 32'h700, 32'h20, 1'b0, 32'h0, mk_exp(1'b1, 1'b1, 1'b0, 32'h720));
    offer(3'b001, 32'h1, 32'h2, 32'h800, 32'h20, 1'b0, 32'h0, mk_exp(1'b1, 1'b1, 1'b0, 32'h820));
    Flush = 1'b1; In_Valid = 1'b1; Out_Ready = 1'b1;
    cycle(a, r1, r2);
    Flush = 1'b0; In_Valid = 1'b0;
    n_tests++;
    if ({r1, r2, a} !== 3'b000) begin
      n_fail++;
      $display("FAIL flush_ready: got rdy1,rdy2,acc=%b, want 000", {r1, r2, a});
    end
    for (int k = 0; k < 3; k++) cycle(a, r1, r2);
    n_tests++;
    if ({ov1, ov2} !== 2'b00) begin
      n_fail++;
      $display("FAIL flush_out_valid: got %b, want 00", {ov1, ov2});
    end
    check_counts("flush_post", 1, 1, 1, 1);
    Out_Ready = 1'b0;
    offer(3'b000, 32'h1, 32'h1, 32'h900, 32'h20, 1'b0, 32'h0, mk_exp(1'b1, 1'b1, 1'b0, 32'h920));
    offer(3'b000, 32'h2, 32'h2, 32'hA00, 32'h20, 1'b0, 32'h0, mk_exp(1'b1, 1'b1, 1'b0, 32'hA20));
    rst = 1'b1;
    cycle(a, r1, r2);
    n_tests++;
    if ({ov1, ov2, rdy1, rdy2, br1, br2, mis1, mis2, rpc1, rpc2} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got ov=%b rdy=%b rpc=%h/%h, want zeros",
               {ov1, ov2}, {rdy1, rdy2}, rpc1, rpc2);
    end
    check_counts("midreset", 0, 0, 0, 0);
    rst = 1'b0; Out_Ready = 1'b1;
    for (int k = 0; k < 3; k++) cycle(a, r1, r2);
    check_counts("postreset", 0, 0, 0, 0);
  endtask

  task automatic test_saturate();
    logic [31:0] pc;
    do_reset();
    Out_Ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      pc = 32'h2000 + 32'(4 * i);
      offer(3'b000, 32'h9, 32'h9, pc, 32'h40, 1'b0, 32'h0, mk_exp(1'b1, 1'b1, 1'b0, pc + 32'h40));
    end
    drain();
    check_counts("saturate", 20, 20, 15, 15);
    offer(3'b011, 32'h1, 32'h1, 32'h3000, 32'h40, 1'b0, 32'h0,
          mk_exp(1'b0, 1'b0, 1'b1, 32'h3004));
    drain();
    check_counts("illegal_nomis", 20, 20, 15, 15);
    offer(3'b010, 32'h1, 32'h1, 32'h3100, 32'h40, 1'b1, 32'h3140,
          mk_exp(1'b0, 1'b1, 1'b1, 32'h3104));
    drain();
    check_counts("illegal_mis", 20, 21, 15, 15);
  endtask

  initial begin
    rst = 1'b1; In_Valid = 1'b0; Flush = 1'b0; Out_Ready = 1'b0;
    Br_Ctrl = 3'b000; SrcA = '0; SrcB = '0; PC = '0; Imm = '0;
    Pred_Taken = 1'b0; Pred_Target = '0; cur_exp = '0;
    test_reset();
    test_latency();
    test_compare();
    test_back_to_back();
    test_random();
    test_flush();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
